// File: rtl/usb_fifo_pkg.sv
// Shared types for the USB<->Ethernet packet-buffer occupancy logic.
package usb_fifo_pkg;

    localparam int PKT_CNT_WIDTH_DEF = 7;

    typedef enum logic {PKT_IDLE, PKT_ACTIVE} pkt_state_t;
    typedef logic [PKT_CNT_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/fifo_flag_gen.sv
// Combinational full/empty/almost flag decode from occupancy counts and depth limit.
// Almost flags are produced only when PKT_FIFO_ALMOST_FLAGS_EN is defined; otherwise tied low.
module fifo_flag_gen #(
    parameter int CNT_WIDTH = 7,
    parameter int AF_MARGIN = 4,
    parameter int AE_MARGIN = 4
) (
    input  logic [CNT_WIDTH-1:0] count,
    input  logic [CNT_WIDTH-1:0] avail,
    input  logic [CNT_WIDTH-1:0] depth_val,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty
);

    assign fifo_full  = (count >= depth_val);
    assign fifo_empty = (count == '0);

`ifdef PKT_FIFO_ALMOST_FLAGS_EN
    localparam logic [CNT_WIDTH-1:0] AF_V = CNT_WIDTH'(AF_MARGIN);
    localparam logic [CNT_WIDTH-1:0] AE_V = CNT_WIDTH'(AE_MARGIN);

    // Free space saturates at zero when the depth limit is lowered below count.
    logic [CNT_WIDTH-1:0] free_space;
    assign free_space   = (depth_val > count) ? (depth_val - count) : '0;
    assign almost_full  = (free_space <= AF_V);
    assign almost_empty = (avail <= AE_V);
`else
    localparam int UNUSED_MARGINS = AF_MARGIN + AE_MARGIN;
    logic unused_avail;
    assign unused_avail = ^avail;
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: rtl/pkt_fifo_occupancy_ctrl.sv
// Packet-aware occupancy controller: total/pending counts with start/commit/error framing.
// Optional almost flags enabled by defining PKT_FIFO_ALMOST_FLAGS_EN.
module pkt_fifo_occupancy_ctrl
    import usb_fifo_pkg::*;
#(
    parameter int CNT_WIDTH = 7,
    parameter int AF_MARGIN = 4,
    parameter int AE_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 start,
    input  logic                 commit,
    input  logic                 error,
    input  logic [CNT_WIDTH-1:0] depth_val,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic [CNT_WIDTH-1:0] avail_count,
    output logic                 pkt_active,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 almost_full,
    output logic                 almost_empty
);

    pkt_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 push_ok, pop_ok, active;
    logic [CNT_WIDTH-1:0] push_inc, pop_dec;

    assign active   = (state_q == PKT_ACTIVE);
    assign push_ok  = push & ~fifo_full;
    assign pop_ok   = pop & (avail_count != '0);
    assign push_inc = CNT_WIDTH'(push_ok);
    assign pop_dec  = CNT_WIDTH'(pop_ok);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pending_d   = pending_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (clear) begin
            state_d   = PKT_IDLE;
            count_d   = '0;
            pending_d = '0;
        end else if (error && active) begin
            // Rollback drops the packet's entries; any concurrent push is discarded silently.
            count_d     = count_q - pending_q - pop_dec;
            pending_d   = '0;
            state_d     = PKT_IDLE;
            underflow_d = pop & ~pop_ok;
        end else begin
            overflow_d  = push & ~push_ok;
            underflow_d = pop & ~pop_ok;
            count_d     = count_q + push_inc - pop_dec;
            if (start && !error) begin
                state_d   = PKT_ACTIVE;
                pending_d = push_inc;
            end else if (commit && active) begin
                state_d   = PKT_IDLE;
                pending_d = '0;
            end else if (active) begin
                pending_d = pending_q + push_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= PKT_IDLE;
            count_q     <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_out   = count_q;
    assign avail_count = count_q - pending_q;
    assign pkt_active  = active;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    fifo_flag_gen #(
        .CNT_WIDTH (CNT_WIDTH),
        .AF_MARGIN (AF_MARGIN),
        .AE_MARGIN (AE_MARGIN)
    ) u_flags (
        .count        (count_q),
        .avail        (avail_count),
        .depth_val    (depth_val),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

endmodule

// File: tb/tb_pkt_fifo_occupancy_ctrl.sv
// Directed and random checks of pkt_fifo_occupancy_ctrl against a committed/pending reference model.
module tb_pkt_fifo_occupancy_ctrl;

    localparam int W  = 4;
    localparam int AF = 2;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         n_rst, clear, push, pop, start, commit, error;
    logic [W-1:0] depth_val;
    logic [W-1:0] count_out, avail_count;
    logic         pkt_active, fifo_full, fifo_empty, overflow, underflow;
    logic         almost_full, almost_empty;

    int total_checks = 0;
    int pass_checks  = 0;

    // Reference model: committed entries, open-packet entries, packet-open flag, pulses.
    int m_comm, m_pend;
    bit m_act, m_ov, m_un;

    always #5 clk = ~clk;

    pkt_fifo_occupancy_ctrl #(.CNT_WIDTH(W), .AF_MARGIN(AF), .AE_MARGIN(AE)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .push(push), .pop(pop),
        .start(start), .commit(commit), .error(error), .depth_val(depth_val),
        .count_out(count_out), .avail_count(avail_count), .pkt_active(pkt_active),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
        .underflow(underflow), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) pass_checks++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_comm = 0; m_pend = 0; m_act = 0; m_ov = 0; m_un = 0;
    endtask

    task automatic model_step(input bit pu, po, st, cm, er, cl);
        int  total;
        bit  pu_ok, po_ok;
        total = m_comm + m_pend;
        pu_ok = pu && (total < int'(depth_val));
        po_ok = po && (m_comm > 0);
        if (cl) begin
            model_reset();
        end else if (er && m_act) begin
            m_pend = 0;
            m_act  = 0;
            m_comm = m_comm - int'(po_ok);
            m_ov   = 0;
            m_un   = po && !po_ok;
        end else begin
            m_ov   = pu && !pu_ok;
            m_un   = po && !po_ok;
            m_comm = m_comm - int'(po_ok);
            if (st && !er) begin
                m_comm = m_comm + m_pend;
                m_pend = 0;
                m_act  = 1;
            end else if (cm && m_act) begin
                m_comm = m_comm + m_pend;
                m_pend = 0;
                m_act  = 0;
            end
            if (pu_ok) begin
                if (m_act) m_pend++;
                else       m_comm++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int  total;
        bit  exp_af, exp_ae;
        total = m_comm + m_pend;
`ifdef PKT_FIFO_ALMOST_FLAGS_EN
        exp_af = (int'(depth_val) > total) ? ((int'(depth_val) - total) <= AF) : 1'b1;
        exp_ae = (m_comm <= AE);
`else
        exp_af = 1'b0;
        exp_ae = 1'b0;
`endif
        chk({tag, ".count"},  count_out,   total);
        chk({tag, ".avail"},  avail_count, m_comm);
        chk({tag, ".active"}, pkt_active,  m_act);
        chk({tag, ".full"},   fifo_full,   total >= int'(depth_val));
        chk({tag, ".empty"},  fifo_empty,  total == 0);
        chk({tag, ".ovf"},    overflow,    m_ov);
        chk({tag, ".udf"},    underflow,   m_un);
        chk({tag, ".afull"},  almost_full, exp_af);
        chk({tag, ".aempty"}, almost_empty, exp_ae);
    endtask

    // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
    task automatic step(input string tag, input bit pu, po, st, cm, er, cl);
        push = pu; pop = po; start = st; commit = cm; error = er; clear = cl;
        @(posedge clk);
        model_step(pu, po, st, cm, er, cl);
        #1;
        check_all(tag);
        @(negedge clk);
        push = 0; pop = 0; start = 0; commit = 0; error = 0; clear = 0;
    endtask

    task automatic async_reset(input string tag);
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".during"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ".after"});
        @(negedge clk);
    endtask

    initial begin
        n_rst = 0; clear = 0; push = 0; pop = 0; start = 0; commit = 0; error = 0;
        depth_val = W'(8);
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        n_rst = 1;
        @(negedge clk);

        // 1: reset while a packet is open with count 5
        step("t1_start", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("t1_push", 1, 0, 0, 0, 0, 0);
        chk("t1_pre_count", count_out, 5);
        async_reset("t1_rst");

        // 2: fill a packet to depth, commit, then overflow
        step("t2_start", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("t2_push", 1, 0, 0, 0, 0, 0);
        step("t2_commit", 0, 0, 0, 1, 0, 0);
        step("t2_ovf", 1, 0, 0, 0, 0, 0);
        chk("t2_ovf_pulse", overflow, 1);
        step("t2_idle", 0, 0, 0, 0, 0, 0);
        chk("t2_count8", count_out, 8);
        chk("t2_avail8", avail_count, 8);
        step("t2_clear", 0, 0, 0, 0, 0, 1);

        // 3: unframed writes, packet with interleaved pops, then error rollback
        for (int i = 0; i < 3; i++) step("t3_unframed", 1, 0, 0, 0, 0, 0);
        step("t3_start", 0, 0, 1, 0, 0, 0);
        step("t3_p", 1, 0, 0, 0, 0, 0);
        step("t3_pop", 0, 1, 0, 0, 0, 0);
        step("t3_p", 1, 0, 0, 0, 0, 0);
        step("t3_pop", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("t3_p", 1, 0, 0, 0, 0, 0);
        step("t3_error", 0, 0, 0, 0, 1, 0);
        chk("t3_count1", count_out, 1);
        step("t3_clear", 0, 0, 0, 0, 0, 1);

        // 4: simultaneous push/pop, drain, then pop at empty
        for (int i = 0; i < 4; i++) step("t4_fill", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("t4_pushpop", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("t4_drain", 0, 1, 0, 0, 0, 0);
        step("t4_udf", 0, 1, 0, 0, 0, 0);
        chk("t4_udf_pulse", underflow, 1);
        step("t4_idle", 0, 0, 0, 0, 0, 0);

        // 5: start while active commits prior packet, then error rolls back only the new one
        step("t5_start", 0, 0, 1, 0, 0, 0);
        step("t5_p", 1, 0, 0, 0, 0, 0);
        step("t5_p", 1, 0, 0, 0, 0, 0);
        step("t5_restart", 1, 0, 1, 0, 0, 0);
        step("t5_error", 0, 0, 0, 0, 1, 0);
        chk("t5_avail2", avail_count, 2);
        step("t5_clear", 0, 0, 0, 0, 0, 1);

        // 6: depth lowered below count
        for (int i = 0; i < 6; i++) step("t6_fill", 1, 0, 0, 0, 0, 0);
        depth_val = W'(4);
        step("t6_ovf", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("t6_pop", 0, 1, 0, 0, 0, 0);
        chk("t6_count3", count_out, 3);
        depth_val = W'(0);
        step("t6_depth0", 1, 0, 0, 0, 0, 0);
        depth_val = W'(8);
        step("t6_clear", 0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 49) == 0) depth_val = W'($urandom_range(0, 15));
            step("rnd",
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end
        async_reset("rnd_rst");

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
